// File: rtl/data_ram_responder.sv
// data_ram_responder
// Memory-side responder for the CPU data port. It accepts one request at a
// time, commits byte-masked writes into an internal word RAM, and returns
// the aligned 32-bit word for reads after a programmable latency.
//
// Handshake:
//   req/addr_ok is a valid/ready pair. A request is taken on a rising edge
//   where req and addr_ok are both 1. The requester holds req and its
//   payload stable until that edge. req while addr_ok=0 is ignored.
//   data_ok is a one-cycle pulse with no back-pressure. rdata and err are
//   only meaningful while data_ok is 1, and they read 0 otherwise.
//
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   req                request valid
//   addr[31:0]         byte address; bits [1:0] are ignored
//   sel[3:0]           byte enables; nonzero = write, 0000 = read
//   wdata[31:0]        write data, already replicated per lane
//   addr_ok            responder can accept this cycle
//   data_ok            one-cycle response pulse
//   rdata[31:0]        read word (0 for writes and out-of-range accesses)
//   err                out-of-range flag for the response
//   busy               a transaction is outstanding and not yet answered
//   dbg_state[1:0]     FSM state, exported for checkers
//
// Parameters:
//   ADDR_W   word-address width; RAM depth is 2^ADDR_W words
//   LATENCY  cycles from the accept edge to the data_ok cycle (1..15)
module data_ram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam logic       LAT_ONE = (LATENCY == 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wr;
  logic              r_oor;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];

  logic              w_accept;
  logic [ADDR_W-1:0] w_idx;
  logic              w_wr;
  logic              w_oor;
  logic              w_enter_resp;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_wr;
  logic              w_rd_oor;
  logic [31:0]       w_resp_data;
  logic [1:0]        w_state_nxt;
  logic              w_unused;

  // Byte offset bits play no part in a word-aligned access.
  assign w_unused = ^addr[1:0];

  assign addr_ok  = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept = req && addr_ok;
  assign w_idx    = addr[ADDR_W+1:2];
  assign w_wr     = |sel;
  assign w_oor    = |(addr >> (ADDR_W + 2));

  // With LATENCY==1 the accept edge is also the edge entering RESP, so the
  // response is built from the incoming request instead of latched fields.
  assign w_enter_resp = (w_accept && LAT_ONE) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_rd_idx = w_accept ? w_idx : r_idx;
  assign w_rd_wr  = w_accept ? w_wr  : r_wr;
  assign w_rd_oor = w_accept ? w_oor : r_oor;

  always_comb begin
    w_resp_data = 32'd0;
    if (!w_rd_wr && !w_rd_oor) begin
      w_resp_data = r_mem[w_rd_idx];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = LAT_ONE ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_accept) w_state_nxt = LAT_ONE ? S_RESP : S_WAIT;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_oor   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx <= w_idx;
        r_wr  <= w_wr;
        r_oor <= w_oor;
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Response fields are loaded only on the edge entering RESP and are
      // cleared otherwise, so they read 0 whenever data_ok is low.
      if (w_enter_resp) begin
        r_rdata <= w_resp_data;
        r_err   <= w_rd_oor;
      end else begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // RAM is not reset. Writes commit on the accept edge, so a read accepted
  // afterwards always sees the merged word.
  always_ff @(posedge clk) begin
    if (w_accept && w_wr && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign data_ok   = (r_state == S_RESP);
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign busy      = (r_state == S_WAIT);
  assign dbg_state = r_state;

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Memory-side responder for the CPU data port. It is the far end of the byte-select / write-data / read-data interface that the MEM-stage select logic drives.
- Accepts one request at a time: address, 4-bit byte enables and replicated write data.
- Performs byte-masked writes into an internal word RAM. Returns the full aligned 32-bit word for reads.
- Response latency is programmable, and a valid/ack handshake lets the pipeline stall on it.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2^ADDR_W words of 32 bits.
- LATENCY, 2, cycles from the accept edge to the data_ok cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req  input  1  request valid; held with its payload until accepted.
- addr  input  32  byte address; bits [1:0] are ignored (word-aligned access).
- sel  input  4  byte enables; nonzero means write, 4'b0000 means read.
- wdata  input  32  write data, already replicated per lane by the requester.
- addr_ok  output  1  responder can accept; a request is accepted on a rising edge where req and addr_ok are both 1.
- data_ok  output  1  one-cycle response pulse.
- rdata  output  32  full read word, valid while data_ok is high.
- err  output  1  out-of-range flag, valid while data_ok is high.
- busy  output  1  a transaction is outstanding and data_ok has not yet been given.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, counter=0.
  - addr_ok=1 after release; data_ok=0, rdata=0, err=0, busy=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - addr_ok = (state==IDLE) or (state==RESP).
- Accept edge (req & addr_ok):
  - Latch word index addr[ADDR_W+1:2], sel, the wr flag (= |sel) and the range flag.
  - Load counter with LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
- Write commit:
  - Happens on the accept edge itself.
  - For each i with sel[i]=1, the RAM byte lane i takes wdata[8i+7:8i]. Other lanes are unchanged.
  - sel patterns are not checked; any nonzero mask is honoured as given.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1, next state is RESP.
  - addr_ok=0 and busy=1 throughout.
- RESP (exactly one cycle):
  - data_ok=1.
  - rdata = RAM word at the latched index for a read; 0 for a write or for out-of-range.
  - err = range flag.
  - If req is high in this cycle, the new request is accepted on the closing edge. This gives a throughput of one transaction per LATENCY cycles.
  - Otherwise the next state is IDLE.
  - rdata and err return to 0 when data_ok is 0.
- Read data sampling:
  - Read data is sampled from the RAM at the edge entering RESP.
  - A read accepted immediately after a write to the same word returns the merged new word.
- Out of range: addr[31:ADDR_W+2] != 0.
  - No RAM write.
  - rdata=0, and err=1 during data_ok.
- busy = (state==WAIT) or (state==RESP and data_ok not yet given). Effectively: 1 from the accept edge until the data_ok cycle, and 0 in the data_ok cycle.
- Simultaneous events:
  - A request presented in the RESP cycle is accepted on that same edge.
  - The response just given is not lost, because data_ok was already observed in that cycle.
- Reset mid-transaction:
  - The pending response is dropped and no data_ok is produced.
  - A write accepted before reset stays committed in the RAM.
- req while addr_ok=0: ignored. The requester must hold req and its payload stable until accepted.

Test Plan:
1. Reset, then LATENCY=2; write sel=1111 addr=0x10 wdata=0xDEADBEEF; read addr=0x10 → write's data_ok 2 cycles after its accept edge with rdata=0; read returns rdata=0xDEADBEEF, err=0.
2. Byte and half lanes: write 0x11223344 to 0x20, then sel=0100 wdata=0xAAAAAAAA, then sel=0011 wdata=0x55665566, then read 0x20 → 0x11AA5566.
3. Back-to-back: req held high for 4 reads, LATENCY=2 → data_ok every 2nd cycle; busy=1 in every non-data_ok cycle; addr_ok low in WAIT cycles only.
4. LATENCY=1: write 0x12345678 to 0x4, read 0x4 on the very next edge → data_ok on consecutive cycles; read rdata=0x12345678.
5. Out of range, ADDR_W=10: write then read addr=0x00001000 → no RAM change (word 0 still reads its prior value); data_ok with err=1, rdata=0.
6. Reset mid-operation: accept read at 0x10, assert resetn=0 during WAIT → no data_ok pulse, outputs at reset values, addr_ok=1 after release; a subsequent read of 0x10 returns the pre-reset written data.
